// File: rtl/modexp_ctrl.sv
// Modular exponentiation controller: drives an external Montgomery multiplier
// through a start/done handshake to compute X^e mod M by left-to-right
// square-and-multiply, then converts the accumulator out of Montgomery form.
module modexp_ctrl (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic [1023:0] in_x,
    input  logic [1023:0] in_one,
    input  logic [1023:0] in_e,
    input  logic [10:0]   in_len,
    input  logic [1023:0] in_m,
    output logic          mm_start,
    output logic [1023:0] mm_a,
    output logic [1023:0] mm_b,
    output logic [1023:0] mm_m,
    input  logic [1024:0] mm_result,
    input  logic          mm_done,
    output logic [1023:0] result,
    output logic          busy,
    output logic          done
);

    localparam int unsigned W  = 1024;
    localparam int unsigned LW = 11;
    localparam int unsigned IW = 10;

    localparam logic [LW-1:0] MAX_LEN = LW'(W);
    localparam logic [W-1:0]  ONE     = W'(1);

    typedef enum logic [2:0] {
        IDLE,
        SQ_ISSUE,
        SQ_WAIT,
        MUL_ISSUE,
        MUL_WAIT,
        OUT_ISSUE,
        OUT_WAIT,
        FIN
    } state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    a_acc, a_nxt;
    logic [W-1:0]    x_reg, x_nxt;
    logic [W-1:0]    e_reg, e_nxt;
    logic [IW-1:0]   idx, idx_nxt;
    logic            mm_start_nxt;
    logic [W-1:0]    mm_a_nxt, mm_b_nxt, mm_m_nxt;
    logic [W-1:0]    result_nxt;
    logic            busy_nxt, done_nxt;
    logic [LW-1:0]   len_clamp;

    // Product from the multiplier; its carry-out bit is never consumed.
    logic [W-1:0]    prod;
    logic            unused_prod_msb;
    assign prod            = mm_result[W-1:0];
    assign unused_prod_msb = mm_result[W];

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            a_acc    <= '0;
            x_reg    <= '0;
            e_reg    <= '0;
            idx      <= '0;
            mm_start <= 1'b0;
            mm_a     <= '0;
            mm_b     <= '0;
            mm_m     <= '0;
            result   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            a_acc    <= a_nxt;
            x_reg    <= x_nxt;
            e_reg    <= e_nxt;
            idx      <= idx_nxt;
            mm_start <= mm_start_nxt;
            mm_a     <= mm_a_nxt;
            mm_b     <= mm_b_nxt;
            mm_m     <= mm_m_nxt;
            result   <= result_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

    // Next-state and next-register values; operands for the following
    // multiplier request are loaded on the same edge that enters its ISSUE state.
    always_comb begin
        state_nxt    = state;
        a_nxt        = a_acc;
        x_nxt        = x_reg;
        e_nxt        = e_reg;
        idx_nxt      = idx;
        mm_start_nxt = 1'b0;
        mm_a_nxt     = mm_a;
        mm_b_nxt     = mm_b;
        mm_m_nxt     = mm_m;
        result_nxt   = result;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        len_clamp    = (in_len > MAX_LEN) ? MAX_LEN : in_len;

        case (state)
            IDLE: begin
                if (start) begin
                    x_nxt        = in_x;
                    e_nxt        = in_e;
                    mm_m_nxt     = in_m;
                    a_nxt        = in_one;
                    idx_nxt      = IW'(len_clamp - LW'(1));
                    busy_nxt     = 1'b1;
                    mm_start_nxt = 1'b1;
                    mm_a_nxt     = in_one;
                    if (len_clamp == '0) begin
                        state_nxt = OUT_ISSUE;
                        mm_b_nxt  = ONE;
                    end else begin
                        state_nxt = SQ_ISSUE;
                        mm_b_nxt  = in_one;
                    end
                end
            end

            SQ_ISSUE:  state_nxt = SQ_WAIT;
            MUL_ISSUE: state_nxt = MUL_WAIT;
            OUT_ISSUE: state_nxt = OUT_WAIT;

            SQ_WAIT: begin
                if (mm_done) begin
                    a_nxt        = prod;
                    mm_start_nxt = 1'b1;
                    mm_a_nxt     = prod;
                    if (e_reg[idx]) begin
                        state_nxt = MUL_ISSUE;
                        mm_b_nxt  = x_reg;
                    end else if (idx == '0) begin
                        state_nxt = OUT_ISSUE;
                        mm_b_nxt  = ONE;
                    end else begin
                        state_nxt = SQ_ISSUE;
                        idx_nxt   = idx - IW'(1);
                        mm_b_nxt  = prod;
                    end
                end
            end

            MUL_WAIT: begin
                if (mm_done) begin
                    a_nxt        = prod;
                    mm_start_nxt = 1'b1;
                    mm_a_nxt     = prod;
                    if (idx == '0) begin
                        state_nxt = OUT_ISSUE;
                        mm_b_nxt  = ONE;
                    end else begin
                        state_nxt = SQ_ISSUE;
                        idx_nxt   = idx - IW'(1);
                        mm_b_nxt  = prod;
                    end
                end
            end

            OUT_WAIT: begin
                if (mm_done) begin
                    a_nxt      = prod;
                    result_nxt = prod;
                    done_nxt   = 1'b1;
                    busy_nxt   = 1'b0;
                    state_nxt  = FIN;
                end
            end

            FIN:     state_nxt = IDLE;

            default: state_nxt = IDLE;
        endcase
    end

endmodule
